// File: rtl/sseg_pkg.sv
// Shared constants and types for the 7-segment display driver.
package sseg_pkg;

  localparam int NUM_DIGITS = 8;

  // Segment pattern, active-high, bit order gfedcba.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_DASH  = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;

  // Hex glyphs 0..F, active-high gfedcba.
  localparam seg_t SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Which glyph source drives the current digit.
  typedef enum logic [1:0] {
    PAT_HEX   = 2'd0,
    PAT_BLANK = 2'd1,
    PAT_DASH  = 2'd2
  } pat_sel_e;

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational nibble to active-high segment pattern lookup.
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);

  assign o_seg = SEG_HEX[i_nibble];

endmodule

// File: rtl/sseg_display_driver.sv
// Scans a 32-bit word as 8 hex digits onto a common-anode 7-segment display.
// Inputs are shadowed once per frame so a digit never mixes two words.
module sseg_display_driver
  import sseg_pkg::*;
#(
  parameter int CYCLES_PER_DIGIT = 100000,
  parameter int CNT_W            = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        empty,
  input  logic        lz_en,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [31:0]      r_sh_value;
  logic             r_sh_empty;
  logic             r_sh_lz;
  logic [7:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic             r_frame_start;

  logic             w_tick;
  logic             w_load;
  logic [3:0]       w_nibble;
  seg_t             w_hex_seg;
  seg_t             w_seg_ah;
  pat_sel_e         w_pat;
  logic [NUM_DIGITS-1:0] w_upper_zero;

  assign w_tick = (r_cnt == CNT_W'(CYCLES_PER_DIGIT - 1));
  // The last tick of digit 7 is the frame boundary.
  assign w_load = w_tick && (r_idx == 3'(NUM_DIGITS - 1));

  // Prescaler and digit index; the index advances once per digit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Frame shadow: all three inputs are captured together at the frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_value <= '0;
      r_sh_empty <= 1'b0;
      r_sh_lz    <= 1'b0;
    end else if (w_load) begin
      r_sh_value <= value;
      r_sh_empty <= empty;
      r_sh_lz    <= lz_en;
    end
  end

  assign w_nibble = r_sh_value[{r_idx, 2'b00} +: 4];

  hex_to_sseg u_hex (
    .i_nibble (w_nibble),
    .o_seg    (w_hex_seg)
  );

  // w_upper_zero[gi] is set when digit gi and every digit to its left are zero.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_upper_zero
    assign w_upper_zero[gi] = (r_sh_value[31:4*gi] == '0);
  end

  // Glyph priority: dash for empty, then leading-zero blank, then hex.
  always_comb begin
    w_pat = PAT_HEX;
    if (r_sh_empty) begin
      w_pat = PAT_DASH;
    end else if (r_sh_lz && (r_idx != 3'd0) && w_upper_zero[r_idx]) begin
      w_pat = PAT_BLANK;
    end
  end

  // Map the selected glyph source to an active-high pattern.
  always_comb begin
    w_seg_ah = w_hex_seg;
    unique case (w_pat)
      PAT_DASH:  w_seg_ah = SEG_DASH;
      PAT_BLANK: w_seg_ah = SEG_BLANK;
      default:   w_seg_ah = w_hex_seg;
    endcase
  end

  // Output register: anode and segments move together, one cycle behind the index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an          <= 8'hFF;
      r_seg         <= 7'h7F;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_an          <= ~(8'b1 << r_idx);
      r_seg         <= ~w_seg_ah;
      r_dp          <= 1'b1;
      r_frame_start <= w_load;
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_sseg_display_driver.sv
// Self-checking bench for sseg_display_driver with a frame-level reference model.
module tb_sseg_display_driver;

  localparam int CPD   = 4;
  localparam int FRAME = CPD * 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] value = '0;
  logic        empty = 1'b0;
  logic        lz_en = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  sseg_display_driver #(
    .CYCLES_PER_DIGIT (CPD),
    .CNT_W            (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .empty       (empty),
    .lz_en       (lz_en),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Hex glyph table, active-high gfedcba.
  function automatic logic [6:0] hex_glyph(input logic [3:0] d);
    case (d)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Active-low segments expected for digit idx of a displayed word.
  function automatic logic [6:0] model_seg(input logic [31:0] v, input logic e,
                                           input logic l, input int idx);
    if (e) return 7'h3F;
    if (l && idx != 0 && (v >> (4 * idx)) == 32'd0) return 7'h7F;
    return ~hex_glyph(v[4*idx +: 4]);
  endfunction

  // Reference model: counts clock edges since reset release; digit = (edges/CPD)%8,
  // shadow captured every FRAME edges. Checks every cycle once reset has been seen.
  initial begin : model
    int          n;
    int          idx;
    logic [31:0] sv;
    logic        se, sl, armed;
    logic [31:0] in_v;
    logic        in_r, in_e, in_l;
    logic [16:0] exp_o;
    logic [7:0]  an_exp;
    n = 0; sv = '0; se = 1'b0; sl = 1'b0; armed = 1'b0; exp_o = '0;
    forever begin
      @(posedge clk);
      in_r = rst; in_v = value; in_e = empty; in_l = lz_en;
      if (in_r) begin
        armed = 1'b1;
        n = 0; sv = '0; se = 1'b0; sl = 1'b0;
        exp_o = {8'hFF, 7'h7F, 1'b1, 1'b0};
      end else begin
        idx    = (n / CPD) % 8;
        an_exp = 8'hFF;
        an_exp[idx] = 1'b0;
        exp_o  = {an_exp, model_seg(sv, se, sl, idx), 1'b1, ((n + 1) % FRAME) == 0};
        n++;
        if (n % FRAME == 0) begin
          sv = in_v; se = in_e; sl = in_l;
        end
      end
      #1;
      if (armed) chk("model{an,seg,dp,fs}", {15'd0, an, seg, dp, frame_start}, {15'd0, exp_o});
    end
  end

  task automatic wait_fs(input string tag);
    bit found = 1'b0;
    for (int k = 0; k < 3 * FRAME && !found; k++) begin
      @(posedge clk); #1;
      if (frame_start) found = 1'b1;
    end
    chk({"frame_start_seen_", tag}, {31'd0, found}, 32'd1);
  endtask

  // Checks one full frame of 8 digits x CPD cycles, starting right after a frame_start.
  // Optionally changes value during digit tear_digit to show it has no effect.
  task automatic check_frame(input logic [55:0] segs, input int tear_digit,
                             input logic [31:0] tear_val);
    logic [7:0] an_exp;
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < CPD; c++) begin
        @(posedge clk); #1;
        an_exp = 8'hFF;
        an_exp[d] = 1'b0;
        chk("frame_an", {24'd0, an}, {24'd0, an_exp});
        chk("frame_seg", {25'd0, seg}, {25'd0, segs[7*d +: 7]});
        if (d == tear_digit && c == 0) begin
          @(negedge clk);
          value = tear_val;
        end
      end
    end
    chk("frame_end_fs", {31'd0, frame_start}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] value;
    logic        empty;
    logic        lz;
    logic [55:0] segs;   // digit i expected at [7i+:7], active-low
  } vec_t;

  vec_t vecs [8];

  initial begin : main
    int k;
    vecs[0] = '{32'h1234ABCD, 1'b0, 1'b0,
                {~7'h06, ~7'h5B, ~7'h4F, ~7'h66, ~7'h77, ~7'h7C, ~7'h39, ~7'h5E}};
    vecs[1] = '{32'h000000A5, 1'b0, 1'b1,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, ~7'h77, ~7'h6D}};
    vecs[2] = '{32'h00000000, 1'b0, 1'b1,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, ~7'h3F}};
    vecs[3] = '{32'h12345678, 1'b1, 1'b0, {8{7'h3F}}};
    vecs[4] = '{32'h12345678, 1'b0, 1'b0,
                {~7'h06, ~7'h5B, ~7'h4F, ~7'h66, ~7'h6D, ~7'h7D, ~7'h07, ~7'h7F}};
    vecs[5] = '{32'hFFFFFFFF, 1'b0, 1'b1, {8{~7'h71}}};
    vecs[6] = '{32'h00F00000, 1'b0, 1'b1,
                {7'h7F, 7'h7F, ~7'h71, ~7'h3F, ~7'h3F, ~7'h3F, ~7'h3F, ~7'h3F}};
    vecs[7] = '{32'h000000A5, 1'b0, 1'b0,
                {~7'h3F, ~7'h3F, ~7'h3F, ~7'h3F, ~7'h3F, ~7'h3F, ~7'h77, ~7'h6D}};

    // Reset held for 3 cycles.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_an", {24'd0, an}, 32'hFF);
      chk("rst_seg", {25'd0, seg}, 32'h7F);
      chk("rst_dp_fs", {30'd0, dp, frame_start}, 32'h2);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_release_an", {24'd0, an}, 32'hFF);
    chk("post_release_seg", {25'd0, seg}, 32'h7F);

    // First frame_start latency.
    k = 0;
    while (k < 100) begin
      @(posedge clk); #1;
      k++;
      if (frame_start) break;
    end
    chk("first_fs_latency", k, FRAME);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      value = vecs[i].value; empty = vecs[i].empty; lz_en = vecs[i].lz;
      $display("[TB] vec %0d: value=%h empty=%0b lz_en=%0b", i, vecs[i].value,
               vecs[i].empty, vecs[i].lz);
      wait_fs($sformatf("vec%0d", i));
      check_frame(vecs[i].segs, -1, 32'd0);
    end

    // Tearing: change value while digit 3 is shown; frame keeps old word.
    @(negedge clk);
    value = 32'h1234ABCD; empty = 1'b0; lz_en = 1'b0;
    $display("[TB] tear: value=1234abcd then ffffffff during digit 3");
    wait_fs("tear");
    check_frame(vecs[0].segs, 3, 32'hFFFFFFFF);
    check_frame({8{~7'h71}}, -1, 32'd0);

    // Reset mid-scan at digit index 5.
    @(negedge clk);
    value = 32'h0; lz_en = 1'b1;
    $display("[TB] reset mid-scan at idx 5");
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_an", {24'd0, an}, 32'hFF);
    chk("midrst_seg_fs", {24'd0, seg, frame_start}, {24'd0, 7'h7F, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_d0_an", {24'd0, an}, 32'hFE);
    chk("midrst_d0_seg", {25'd0, seg}, {25'd0, ~7'h3F});
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    chk("midrst_d1_an", {24'd0, an}, 32'hFD);
    chk("midrst_d1_seg_nolz", {25'd0, seg}, {25'd0, ~7'h3F});

    // Randomized phase, checked by the reference model every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 249) == 0) begin
        rst = 1'b1;
        $display("[TB] rand cycle %0d: reset", i);
      end
      if ($urandom_range(0, 23) == 0) begin
        case ($urandom_range(0, 3))
          0: value = $urandom;
          1: value = $urandom_range(0, 255);
          2: value = 32'd1 << (4 * $urandom_range(0, 7));
          default: value = 32'd0;
        endcase
        empty = ($urandom_range(0, 5) == 0);
        lz_en = $urandom_range(0, 1) == 1;
        $display("[TB] rand cycle %0d: value=%h empty=%0b lz_en=%0b", i, value, empty, lz_en);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
